priority_resolver_n: RTL and testbench

- Clocked, parametrised successor to the 8259A-style priority resolver; serves NUM_IRQ request lines.
- Holds the IRR, ISR and IMR registers and a rotating priority pointer.
- Implements the fully nested, fixed, automatic-rotate and specific-rotate modes, plus the two-pulse INTA handshake.
- Sits between the IR pins and the PIC control/data-bus logic, which decodes OCW1/OCW2 into the command ports below.

---
 rtl/priority_resolver_n.sv | 219 +++++++++++++++++++++
 tb/tb_priority_resolver_n.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_n.sv
// priority_resolver_n
// Clocked, parametrised 8259A-style priority resolver. Holds IRR, ISR and IMR
// plus a rotating lowest-priority pointer, resolves fully nested priority and
// runs the two-pulse INTA handshake. OCW2-style commands arrive pre-decoded.
module priority_resolver_n #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] ir,
    input  logic [NUM_IRQ-1:0] trig_level,
    input  logic               aeoi,
    input  logic               imr_wr,
    input  logic [NUM_IRQ-1:0] imr_din,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [VEC_W-1:0]   cmd_level,
    input  logic               inta,
    output logic               int_o,
    output logic [VEC_W-1:0]   int_vec,
    output logic               vec_valid,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] imr
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK2 = 1'b1
    } state_t;

    // Command encodings {R, SL, EOI}
    localparam logic [2:0] OP_CLR_ROT  = 3'b000;
    localparam logic [2:0] OP_NS_EOI   = 3'b001;
    localparam logic [2:0] OP_NOP      = 3'b010;
    localparam logic [2:0] OP_SP_EOI   = 3'b011;
    localparam logic [2:0] OP_SET_ROT  = 3'b100;
    localparam logic [2:0] OP_ROT_NS   = 3'b101;
    localparam logic [2:0] OP_SET_PRIO = 3'b110;
    localparam logic [2:0] OP_ROT_SP   = 3'b111;

    state_t               state;
    state_t               state_next;
    logic [VEC_W-1:0]     ptr;
    logic [VEC_W-1:0]     ptr_next;
    logic                 rot_aeoi;
    logic                 rot_aeoi_next;
    logic                 spurious;
    logic                 spurious_next;
    logic [NUM_IRQ-1:0]   ir_prev;
    logic [VEC_W-1:0]     int_vec_next;
    logic                 vec_valid_next;
    logic [NUM_IRQ-1:0]   irr_next;
    logic [NUM_IRQ-1:0]   isr_next;
    logic [NUM_IRQ-1:0]   imr_next;

    logic [NUM_IRQ-1:0]   cand;
    logic [NUM_IRQ-1:0]   cand_rot;
    logic [NUM_IRQ-1:0]   isr_rot;
    logic                 cand_any;
    logic                 isr_any;
    logic [VEC_W-1:0]     cand_rank;
    logic [VEC_W-1:0]     isr_rank;
    logic                 win_valid;
    logic [VEC_W-1:0]     win_idx;
    logic [VEC_W-1:0]     isr_top;

    logic [NUM_IRQ-1:0]   set_mask;
    logic [NUM_IRQ-1:0]   grant_clr;
    logic [NUM_IRQ-1:0]   isr_clr;

    // Rotate a request vector so bit k holds channel (p+1+k) mod N, i.e. bit 0
    // is the highest-priority channel for pointer p.
    function automatic logic [NUM_IRQ-1:0] rotate_req(input logic [NUM_IRQ-1:0] req,
                                                      input logic [VEC_W-1:0]   p);
        logic [2*NUM_IRQ-1:0] dbl;
        dbl = {req, req} >> (int'(p) + 1);
        return dbl[NUM_IRQ-1:0];
    endfunction

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = VEC_W'(k);
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
        return NUM_IRQ'(1) << idx;
    endfunction

    // Priority resolution: rank candidates and in-service bits relative to the
    // pointer; a candidate only wins if it outranks everything in service.
    always_comb begin
        cand      = irr & ~imr;
        cand_rot  = rotate_req(cand, ptr);
        isr_rot   = rotate_req(isr, ptr);
        cand_any  = |cand;
        isr_any   = |isr;
        cand_rank = lowest_set(cand_rot);
        isr_rank  = lowest_set(isr_rot);
        win_valid = cand_any && (!isr_any || (cand_rank < isr_rank));
        win_idx   = ptr + cand_rank + VEC_W'(1);
        isr_top   = ptr + isr_rank + VEC_W'(1);
        int_o     = win_valid && (state == IDLE);
    end

    // Next-state logic: INTA handshake, AEOI, OCW2 commands and register updates.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        rot_aeoi_next  = rot_aeoi;
        spurious_next  = spurious;
        int_vec_next   = int_vec;
        vec_valid_next = 1'b0;
        set_mask       = '0;
        grant_clr      = '0;
        isr_clr        = '0;

        case (state)
            IDLE: begin
                if (inta) begin
                    state_next = ACK2;
                    if (win_valid) begin
                        int_vec_next  = win_idx;
                        set_mask      = onehot(win_idx);
                        grant_clr     = onehot(win_idx);
                        spurious_next = 1'b0;
                    end else begin
                        int_vec_next  = '1;
                        spurious_next = 1'b1;
                    end
                end
            end
            ACK2: begin
                if (inta) begin
                    state_next     = IDLE;
                    vec_valid_next = 1'b1;
                    if (aeoi && !spurious) begin
                        isr_clr = isr_clr | onehot(int_vec);
                        if (rot_aeoi) begin
                            ptr_next = int_vec;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Commands act on the pre-cycle ISR; a pointer change by command takes
        // precedence over an AEOI rotation in the same cycle.
        if (cmd_valid) begin
            case (cmd_op)
                OP_NS_EOI, OP_ROT_NS: begin
                    if (isr_any) begin
                        isr_clr = isr_clr | onehot(isr_top);
                        if (cmd_op[2]) begin
                            ptr_next = isr_top;
                        end
                    end
                end
                OP_SP_EOI, OP_ROT_SP: begin
                    if (isr_any) begin
                        isr_clr = isr_clr | onehot(cmd_level);
                        if (cmd_op[2]) begin
                            ptr_next = cmd_level;
                        end
                    end
                end
                OP_SET_ROT:  rot_aeoi_next = 1'b1;
                OP_CLR_ROT:  rot_aeoi_next = 1'b0;
                OP_SET_PRIO: ptr_next      = cmd_level;
                OP_NOP:      ;
                default:     ;
            endcase
        end

        irr_next = (trig_level & ir & ~grant_clr)
                 | (~trig_level & ((irr & ~grant_clr) | (ir & ~ir_prev)));
        isr_next = (isr & ~isr_clr) | set_mask;
        imr_next = imr_wr ? imr_din : imr;
    end

    // State and register update; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '1;
            rot_aeoi  <= 1'b0;
            spurious  <= 1'b0;
            ir_prev   <= '0;
            int_vec   <= '0;
            vec_valid <= 1'b0;
            irr       <= '0;
            isr       <= '0;
            imr       <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            rot_aeoi  <= rot_aeoi_next;
            spurious  <= spurious_next;
            ir_prev   <= ir;
            int_vec   <= int_vec_next;
            vec_valid <= vec_valid_next;
            irr       <= irr_next;
            isr       <= isr_next;
            imr       <= imr_next;
        end
    end

endmodule

// File: tb/tb_priority_resolver_n.sv
// Testbench for priority_resolver_n: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of the resolver rules.
module tb_priority_resolver_n;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir;
    logic [7:0] trig_level;
    logic       aeoi;
    logic       imr_wr;
    logic [7:0] imr_din;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [2:0] cmd_level;
    logic       inta;
    logic       int_o;
    logic [2:0] int_vec;
    logic       vec_valid;
    logic [7:0] isr;
    logic [7:0] irr;
    logic [7:0] imr;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit [7:0] m_irr, m_isr, m_imr, m_prev;
    int       m_p, m_vec;
    bit       m_ack, m_spur, m_rot, m_vv;

    priority_resolver_n #(.NUM_IRQ(N)) dut (
        .clk(clk), .reset(reset), .ir(ir), .trig_level(trig_level), .aeoi(aeoi),
        .imr_wr(imr_wr), .imr_din(imr_din), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_level(cmd_level), .inta(inta), .int_o(int_o), .int_vec(int_vec),
        .vec_valid(vec_valid), .isr(isr), .irr(irr), .imr(imr)
    );

    always #5 clk = ~clk;

    // Highest-priority set channel of v for pointer p, scanning upward from p+1.
    function automatic int top_of(bit [7:0] v, int p);
        for (int r = 0; r < N; r++) begin
            int c;
            c = (p + 1 + r) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int rank_of(int c, int p);
        return (c - p - 1 + 2 * N) % N;
    endfunction

    function automatic int m_winner();
        int c, s;
        c = top_of(m_irr & ~m_imr, m_p);
        s = top_of(m_isr, m_p);
        if (c < 0) return -1;
        if (s >= 0 && rank_of(c, m_p) >= rank_of(s, m_p)) return -1;
        return c;
    endfunction

    function automatic bit m_int_o();
        return (m_winner() >= 0) && !m_ack;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int       w, h, op;
        bit [7:0] set_m, clr_m, grant_m, n_irr;
        bit       n_ack, n_spur, n_rot, n_vv;
        int       n_p, n_vec;
        if (reset) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_prev = 0; m_p = N - 1;
            m_ack = 0; m_spur = 0; m_rot = 0; m_vv = 0; m_vec = 0;
            return;
        end
        w = m_winner();
        set_m = 0; clr_m = 0; grant_m = 0;
        n_ack = m_ack; n_spur = m_spur; n_rot = m_rot; n_vv = 0; n_p = m_p; n_vec = m_vec;
        if (inta && !m_ack) begin
            n_ack = 1;
            if (w >= 0) begin
                n_vec = w; set_m = 8'(1 << w); grant_m = 8'(1 << w); n_spur = 0;
            end else begin
                n_vec = N - 1; n_spur = 1;
            end
        end else if (inta && m_ack) begin
            n_ack = 0; n_vv = 1;
            if (aeoi && !m_spur) begin
                clr_m = clr_m | 8'(1 << m_vec);
                if (m_rot) n_p = m_vec;
            end
        end
        if (cmd_valid) begin
            op = int'(cmd_op);
            if ((op == 1 || op == 5) && m_isr != 0) begin
                h = top_of(m_isr, m_p);
                clr_m = clr_m | 8'(1 << h);
                if (op == 5) n_p = h;
            end else if ((op == 3 || op == 7) && m_isr != 0) begin
                clr_m = clr_m | 8'(1 << cmd_level);
                if (op == 7) n_p = int'(cmd_level);
            end else if (op == 4) begin
                n_rot = 1;
            end else if (op == 0) begin
                n_rot = 0;
            end else if (op == 6) begin
                n_p = int'(cmd_level);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (trig_level[i]) n_irr[i] = ir[i] & ~grant_m[i];
            else               n_irr[i] = (m_irr[i] & ~grant_m[i]) | (ir[i] & ~m_prev[i]);
        end
        m_isr  = (m_isr & ~clr_m) | set_m;
        m_irr  = n_irr;
        if (imr_wr) m_imr = imr_din;
        m_prev = ir;
        m_ack = n_ack; m_spur = n_spur; m_rot = n_rot; m_vv = n_vv; m_p = n_p; m_vec = n_vec;
    endtask

    // One clock: step the model, take the edge, then drop one-cycle pulses.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        inta = 1'b0; cmd_valid = 1'b0; imr_wr = 1'b0;
    endtask

    task automatic issue_cmd(input logic [2:0] op, input logic [2:0] lvl);
        cmd_valid = 1'b1; cmd_op = op; cmd_level = lvl;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (irr !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_irr: got %h want 00", irr); end
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_isr: got %h want 00", isr); end
        n_checks++; if (imr !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_imr: got %h want 00", imr); end
        n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_int_o: got %b want 0", int_o); end
        n_checks++; if (int_vec !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_int_vec: got %0d want 0", int_vec); end
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vec_valid: got %b want 0", vec_valid); end
        reset = 1'b0;
    endtask

    task automatic test_fixed();
        ir = 8'h81; tick();
        n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fixed_int_o: got %b want 1", int_o); end
        inta = 1'b1; tick();
        n_checks++; if (isr !== 8'h01) begin n_fail++; $display("[TB] FAIL fixed_isr: got %h want 01", isr); end
        n_checks++; if (irr !== 8'h80) begin n_fail++; $display("[TB] FAIL fixed_irr: got %h want 80", irr); end
        n_checks++; if (int_vec !== 3'd0) begin n_fail++; $display("[TB] FAIL fixed_vec0: got %0d want 0", int_vec); end
        n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fixed_int_o_ack2: got %b want 0", int_o); end
        inta = 1'b1; tick();
        n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL fixed_vec_valid: got %b want 1", vec_valid); end
        tick();
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fixed_vec_valid_pulse: got %b want 0", vec_valid); end
        n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fixed_nested_block: got %b want 0", int_o); end
        ir = 8'h80; issue_cmd(3'b001, 3'd0);
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("[TB] FAIL fixed_eoi_isr: got %h want 00", isr); end
        n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fixed_eoi_int_o: got %b want 1", int_o); end
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd7) begin n_fail++; $display("[TB] FAIL fixed_vec7: got %0d want 7", int_vec); end
        inta = 1'b1; tick();
        ir = 8'h00; issue_cmd(3'b001, 3'd0);
        tick();
    endtask

    task automatic test_rotate_specific();
        int order [3] = '{4, 5, 0};
        ir = 8'h31; issue_cmd(3'b110, 3'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_int_o[%0d]: got %b want 1", k, int_o); end
            inta = 1'b1; tick();
            n_checks++; if (int_vec !== 3'(order[k])) begin n_fail++; $display("[TB] FAIL prio_vec[%0d]: got %0d want %0d", k, int_vec, order[k]); end
            n_checks++; if (isr !== 8'(1 << order[k])) begin n_fail++; $display("[TB] FAIL prio_isr[%0d]: got %h want %h", k, isr, 8'(1 << order[k])); end
            ir = ir & ~8'(1 << order[k]);
            inta = 1'b1; tick();
            if (order[k] == 0) issue_cmd(3'b011, 3'd0);
            else               issue_cmd(3'b001, 3'd0);
            n_checks++; if (isr !== 8'h00) begin n_fail++; $display("[TB] FAIL prio_eoi[%0d]: got %h want 00", k, isr); end
        end
        issue_cmd(3'b110, 3'd7);
    endtask

    task automatic test_rotate_aeoi();
        aeoi = 1'b1;
        issue_cmd(3'b100, 3'd0);
        ir = 8'h48; tick();
        n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL aeoi_int_o: got %b want 1", int_o); end
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd3) begin n_fail++; $display("[TB] FAIL aeoi_vec_a: got %0d want 3", int_vec); end
        inta = 1'b1; tick();
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("[TB] FAIL aeoi_isr: got %h want 00", isr); end
        n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL aeoi_vec_valid: got %b want 1", vec_valid); end
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd6) begin n_fail++; $display("[TB] FAIL aeoi_vec_b: got %0d want 6", int_vec); end
        inta = 1'b1; tick();
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd3) begin n_fail++; $display("[TB] FAIL aeoi_vec_c: got %0d want 3", int_vec); end
        inta = 1'b1; tick();
        ir = 8'h00; aeoi = 1'b0;
        issue_cmd(3'b000, 3'd0);
        issue_cmd(3'b110, 3'd7);
    endtask

    task automatic test_mask();
        imr_wr = 1'b1; imr_din = 8'h01; tick();
        ir = 8'h03; tick();
        n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mask_int_o: got %b want 1", int_o); end
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd1) begin n_fail++; $display("[TB] FAIL mask_vec: got %0d want 1", int_vec); end
        n_checks++; if (isr !== 8'h02) begin n_fail++; $display("[TB] FAIL mask_isr: got %h want 02", isr); end
        inta = 1'b1; tick();
        imr_wr = 1'b1; imr_din = 8'hFF; issue_cmd(3'b001, 3'd0);
        n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mask_all_int_o: got %b want 0", int_o); end
        n_checks++; if (irr !== 8'h03) begin n_fail++; $display("[TB] FAIL mask_irr: got %h want 03", irr); end
        imr_wr = 1'b1; imr_din = 8'h00; ir = 8'h00; tick();
        tick();
    endtask

    task automatic test_edge();
        trig_level = 8'hFE; ir = 8'h00; tick();
        ir = 8'h01; tick();
        n_checks++; if (irr !== 8'h01) begin n_fail++; $display("[TB] FAIL edge_capture: got %h want 01", irr); end
        inta = 1'b1; tick();
        n_checks++; if (irr !== 8'h00) begin n_fail++; $display("[TB] FAIL edge_grant_clr: got %h want 00", irr); end
        inta = 1'b1; tick();
        issue_cmd(3'b001, 3'd0);
        n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL edge_no_rerequest: got %b want 0", int_o); end
        ir = 8'h00; tick();
        ir = 8'h01; tick();
        n_checks++; if (irr !== 8'h01) begin n_fail++; $display("[TB] FAIL edge_reset_bit: got %h want 01", irr); end
        imr_wr = 1'b1; imr_din = 8'h01; tick();
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd7) begin n_fail++; $display("[TB] FAIL spurious_vec: got %0d want 7", int_vec); end
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("[TB] FAIL spurious_isr: got %h want 00", isr); end
        inta = 1'b1; tick();
        n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL spurious_vec_valid: got %b want 1", vec_valid); end
        trig_level = 8'hFF; ir = 8'h00; imr_wr = 1'b1; imr_din = 8'h00; tick();
    endtask

    task automatic test_nest_reset_ack2();
        reset = 1'b1; tick(); reset = 1'b0;
        ir = 8'h08; tick();
        inta = 1'b1; tick();
        inta = 1'b1; tick();
        ir = 8'h20; tick();
        n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL nest_block: got %b want 0", int_o); end
        ir = 8'h22; tick();
        n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL nest_preempt: got %b want 1", int_o); end
        inta = 1'b1; tick();
        n_checks++; if (int_vec !== 3'd1) begin n_fail++; $display("[TB] FAIL nest_vec: got %0d want 1", int_vec); end
        n_checks++; if (isr !== 8'h0A) begin n_fail++; $display("[TB] FAIL nest_isr: got %h want 0a", isr); end
        reset = 1'b1; inta = 1'b1; tick();
        n_checks++; if ({isr, irr, imr} !== 24'h0) begin n_fail++; $display("[TB] FAIL ack2_reset_regs: got %h want 000000", {isr, irr, imr}); end
        n_checks++; if ({int_o, int_vec, vec_valid} !== 5'b0) begin n_fail++; $display("[TB] FAIL ack2_reset_outs: got %b want 00000", {int_o, int_vec, vec_valid}); end
        reset = 1'b0; tick();
        n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ack2_reset_no_vec: got %b want 0", vec_valid); end
        ir = 8'h00; tick();
    endtask

    task automatic test_random();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 300 == 0) begin
                trig_level = 8'($urandom);
                aeoi       = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) ir = ir ^ 8'(1 << $urandom_range(0, 7));
            inta      = ($urandom_range(0, 3) == 0);
            cmd_valid = ($urandom_range(0, 5) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_level = 3'($urandom_range(0, 7));
            imr_wr    = ($urandom_range(0, 24) == 0);
            imr_din   = 8'($urandom) & 8'($urandom);
            tick();
            n_checks++; if (int_o !== m_int_o()) begin n_fail++; $display("[TB] FAIL rnd_int_o @%0d: got %b want %b", cyc, int_o, m_int_o()); end
            n_checks++; if (int_vec !== 3'(m_vec)) begin n_fail++; $display("[TB] FAIL rnd_int_vec @%0d: got %0d want %0d", cyc, int_vec, m_vec); end
            n_checks++; if (vec_valid !== m_vv) begin n_fail++; $display("[TB] FAIL rnd_vec_valid @%0d: got %b want %b", cyc, vec_valid, m_vv); end
            n_checks++; if (isr !== m_isr) begin n_fail++; $display("[TB] FAIL rnd_isr @%0d: got %h want %h", cyc, isr, m_isr); end
            n_checks++; if (irr !== m_irr) begin n_fail++; $display("[TB] FAIL rnd_irr @%0d: got %h want %h", cyc, irr, m_irr); end
            n_checks++; if (imr !== m_imr) begin n_fail++; $display("[TB] FAIL rnd_imr @%0d: got %h want %h", cyc, imr, m_imr); end
        end
        reset = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1; ir = 8'h00; trig_level = 8'hFF; aeoi = 1'b0;
        imr_wr = 1'b0; imr_din = 8'h00; cmd_valid = 1'b0; cmd_op = 3'b010;
        cmd_level = 3'd0; inta = 1'b0;
        #1;
        test_reset();
        test_fixed();
        test_rotate_specific();
        test_rotate_aeoi();
        test_mask();
        test_edge();
        test_nest_reset_ack2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
